// File: rtl/mac_seq_pkg.sv
// Shared types and helpers for the MAC dot-product sequencer.
// Holds the FSM state encoding, the float32 zero constant and a latency helper.
package mac_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    ISSUE,
    DRAIN,
    HOLD
  } seq_state_t;

  localparam logic [31:0] FP32_ZERO = 32'h0;

  // Cycles from command handshake to res_valid for a run of len pairs.
  function automatic int unsigned total_latency(input int unsigned clr_wait,
                                                input int unsigned drain_cycles,
                                                input int unsigned len);
    return 1 + clr_wait + len + 1 + drain_cycles;
  endfunction

endpackage

// File: rtl/mac_seq_addr_gen.sv
// Operand address generator: base + i*stride via an accumulating adder, one read per cycle.
// en rises the cycle after start and stays high for len cycles; last flags the final read.
module mac_seq_addr_gen
  import mac_seq_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int LEN_W  = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W-1:0] stride,
  input  logic [LEN_W-1:0]  len,
  input  logic              start,
  output logic              en,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] stride_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  cnt;

  assign last = en && (cnt == len_q - LEN_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      base_q   <= '0;
      stride_q <= '0;
      len_q    <= '0;
      cnt      <= '0;
      en       <= 1'b0;
      addr     <= '0;
    end else begin
      if (load) begin
        base_q   <= base;
        stride_q <= stride;
        len_q    <= len;
      end
      if (start) begin
        en   <= 1'b1;
        addr <= base_q;
        cnt  <= '0;
      end else if (en) begin
        if (last) begin
          en <= 1'b0;
        end else begin
          // Address wraps naturally modulo 2^ADDR_W.
          addr <= addr + stride_q;
          cnt  <= cnt + LEN_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/mac_dot_sequencer.sv
// Dot-product sequencer: clears the MAC, streams len SRAM operand pairs, drains, returns the sum.
// Latency 1+CLR_WAIT+len+1+DRAIN_CYCLES; result held until res_ready. MAC_SEQ_STRIDE_EN adds strides.
module mac_dot_sequencer
  import mac_seq_pkg::*;
#(
  parameter int ADDR_W       = 10,
  parameter int LEN_W        = 11,
  parameter int CLR_WAIT     = 2,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_base_a,
  input  logic [ADDR_W-1:0] cmd_base_b,
  input  logic [LEN_W-1:0]  cmd_len,
`ifdef MAC_SEQ_STRIDE_EN
  input  logic [ADDR_W-1:0] cmd_stride_a,
  input  logic [ADDR_W-1:0] cmd_stride_b,
`endif
  output logic              mem_a_en,
  output logic [ADDR_W-1:0] mem_a_addr,
  input  logic [31:0]       mem_a_rdata,
  output logic              mem_b_en,
  output logic [ADDR_W-1:0] mem_b_addr,
  input  logic [31:0]       mem_b_rdata,
  output logic [31:0]       mac_data_a,
  output logic [31:0]       mac_data_b,
  output logic              mac_valid,
  output logic              mac_clear,
  input  logic [31:0]       mac_data_out,
  input  logic              mac_overflow,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [31:0]       res_data,
  output logic              res_overflow,
  output logic              busy
);

  localparam int CW_W = $clog2(CLR_WAIT + 2);
  localparam int DC_W = $clog2(DRAIN_CYCLES + 2);

  seq_state_t        state;
  logic [CW_W-1:0]   clr_cnt;
  logic [DC_W-1:0]   drn_cnt;
  logic              len_zero;
  logic              ovf_sticky;
  logic              cmd_fire;
  logic              issue_start;
  logic              a_last;
  logic              b_last;
  logic [ADDR_W-1:0] stride_a;
  logic [ADDR_W-1:0] stride_b;

`ifdef MAC_SEQ_STRIDE_EN
  assign stride_a = cmd_stride_a;
  assign stride_b = cmd_stride_b;
`else
  assign stride_a = ADDR_W'(1);
  assign stride_b = ADDR_W'(1);
`endif

  assign cmd_fire    = cmd_valid && cmd_ready;
  assign issue_start = (state == CLR) && (clr_cnt == CW_W'(CLR_WAIT)) && !len_zero;

  // SRAM read data lines up with the registered mac_valid, so it passes straight through.
  assign mac_data_a = mem_a_rdata;
  assign mac_data_b = mem_b_rdata;

  mac_seq_addr_gen #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) u_gen_a (
    .clk    (clk),
    .rst    (rst),
    .load   (cmd_fire),
    .base   (cmd_base_a),
    .stride (stride_a),
    .len    (cmd_len),
    .start  (issue_start),
    .en     (mem_a_en),
    .addr   (mem_a_addr),
    .last   (a_last)
  );

  mac_seq_addr_gen #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) u_gen_b (
    .clk    (clk),
    .rst    (rst),
    .load   (cmd_fire),
    .base   (cmd_base_b),
    .stride (stride_b),
    .len    (cmd_len),
    .start  (issue_start),
    .en     (mem_b_en),
    .addr   (mem_b_addr),
    .last   (b_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cmd_ready    <= 1'b1;
      busy         <= 1'b0;
      mac_clear    <= 1'b0;
      mac_valid    <= 1'b0;
      res_valid    <= 1'b0;
      res_data     <= FP32_ZERO;
      res_overflow <= 1'b0;
      clr_cnt      <= '0;
      drn_cnt      <= '0;
      len_zero     <= 1'b0;
      ovf_sticky   <= 1'b0;
    end else begin
      mac_clear <= 1'b0;
      mac_valid <= mem_a_en;
      case (state)
        IDLE: begin
          if (cmd_fire) begin
            state      <= CLR;
            cmd_ready  <= 1'b0;
            busy       <= 1'b1;
            mac_clear  <= 1'b1;
            clr_cnt    <= '0;
            len_zero   <= (cmd_len == '0);
            ovf_sticky <= 1'b0;
          end
        end
        CLR: begin
          // The clear cycle itself may still show the previous run's flag.
          if (clr_cnt != '0) ovf_sticky <= ovf_sticky | mac_overflow;
          if (clr_cnt == CW_W'(CLR_WAIT)) begin
            drn_cnt <= '0;
            state   <= len_zero ? DRAIN : ISSUE;
          end else begin
            clr_cnt <= clr_cnt + CW_W'(1);
          end
        end
        ISSUE: begin
          ovf_sticky <= ovf_sticky | mac_overflow;
          if (a_last && b_last) begin
            drn_cnt <= '0;
            state   <= DRAIN;
          end
        end
        DRAIN: begin
          ovf_sticky <= ovf_sticky | mac_overflow;
          // The first drain cycle covers the mac_valid register stage, then count quiet cycles.
          if (drn_cnt == '0) begin
            drn_cnt <= DC_W'(1);
          end else if (!mac_valid) begin
            if (drn_cnt >= DC_W'(DRAIN_CYCLES)) begin
              res_data     <= mac_data_out;
              res_overflow <= ovf_sticky | mac_overflow;
              res_valid    <= 1'b1;
              state        <= HOLD;
            end else begin
              drn_cnt <= drn_cnt + DC_W'(1);
            end
          end
        end
        HOLD: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_dot_sequencer.sv
// Bench for mac_dot_sequencer with SRAM and float MAC models, a vector table and a result scoreboard.
module tb_mac_dot_sequencer;
  import mac_seq_pkg::*;

  localparam int ADDR_W       = 10;
  localparam int LEN_W        = 11;
  localparam int CLR_WAIT     = 2;
  localparam int DRAIN_CYCLES = 4;

  logic              clk;
  logic              rst;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_base_a;
  logic [ADDR_W-1:0] cmd_base_b;
  logic [LEN_W-1:0]  cmd_len;
  logic              mem_a_en;
  logic [ADDR_W-1:0] mem_a_addr;
  logic [31:0]       mem_a_rdata;
  logic              mem_b_en;
  logic [ADDR_W-1:0] mem_b_addr;
  logic [31:0]       mem_b_rdata;
  logic [31:0]       mac_data_a;
  logic [31:0]       mac_data_b;
  logic              mac_valid;
  logic              mac_clear;
  logic [31:0]       mac_data_out;
  logic              mac_overflow;
  logic              res_valid;
  logic              res_ready;
  logic [31:0]       res_data;
  logic              res_overflow;
  logic              busy;

  mac_dot_sequencer #(
    .ADDR_W(ADDR_W), .LEN_W(LEN_W), .CLR_WAIT(CLR_WAIT), .DRAIN_CYCLES(DRAIN_CYCLES)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_base_a(cmd_base_a), .cmd_base_b(cmd_base_b), .cmd_len(cmd_len),
    .mem_a_en(mem_a_en), .mem_a_addr(mem_a_addr), .mem_a_rdata(mem_a_rdata),
    .mem_b_en(mem_b_en), .mem_b_addr(mem_b_addr), .mem_b_rdata(mem_b_rdata),
    .mac_data_a(mac_data_a), .mac_data_b(mac_data_b),
    .mac_valid(mac_valid), .mac_clear(mac_clear),
    .mac_data_out(mac_data_out), .mac_overflow(mac_overflow),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_overflow(res_overflow),
    .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [31:0] mem_a [1024];
  logic [31:0] mem_b [1024];

  always @(posedge clk) begin
    if (mem_a_en) mem_a_rdata <= mem_a[mem_a_addr];
    if (mem_b_en) mem_b_rdata <= mem_b[mem_b_addr];
  end

  // Float32 <-> real conversion for normal numbers; overflowing values become infinity.
  function automatic real f2r(input logic [31:0] f);
    logic [63:0] d;
    if (f[30:0] == 31'd0) return 0.0;
    d = {f[31], {3'b000, f[30:23]} + 11'd896, f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real x);
    logic [63:0] d;
    logic [11:0] e;
    if (x == 0.0) return 32'h0;
    d = $realtobits(x);
    e = {1'b0, d[62:52]} - 12'd896;
    if (e >= 12'd255) return {d[63], 8'hFF, 23'd0};
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic fp_ovf(input real x);
    logic [31:0] f;
    f = r2f(x);
    return f[30:23] == 8'hFF;
  endfunction

  // Behavioural MAC: single-cycle clear, overflow flag pulses only on overflowing accumulations.
  real acc_r;
  always @(posedge clk) begin
    if (mac_clear) begin
      acc_r        <= 0.0;
      mac_data_out <= 32'h0;
      mac_overflow <= 1'b0;
    end else if (mac_valid) begin
      acc_r        <= acc_r + f2r(mac_data_a) * f2r(mac_data_b);
      mac_data_out <= r2f(acc_r + f2r(mac_data_a) * f2r(mac_data_b));
      mac_overflow <= fp_ovf(acc_r + f2r(mac_data_a) * f2r(mac_data_b));
    end else begin
      mac_overflow <= 1'b0;
    end
  end

  typedef struct {
    logic [ADDR_W-1:0] base_a;
    logic [ADDR_W-1:0] base_b;
    logic [LEN_W-1:0]  len;
    logic [31:0]       exp_data;
    logic              exp_ovf;
    int                hold;
    bit                early;
  } vec_t;

  vec_t         vecs[5];
  logic [32:0]  sb_q[$];
  int           n_checks = 0;
  int           n_err    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_mem_a_en"}, 32'(mem_a_en), 32'd0);
    chk({tag, "_mem_b_en"}, 32'(mem_b_en), 32'd0);
    chk({tag, "_mem_a_addr"}, 32'(mem_a_addr), 32'd0);
    chk({tag, "_mac_valid"}, 32'(mac_valid), 32'd0);
    chk({tag, "_mac_clear"}, 32'(mac_clear), 32'd0);
    chk({tag, "_res_valid"}, 32'(res_valid), 32'd0);
    chk({tag, "_res_data"}, res_data, 32'd0);
    chk({tag, "_res_ovf"}, 32'(res_overflow), 32'd0);
  endtask

  // Issue one command, trace it to its result and compare against the scoreboard entry.
  task automatic run_cmd(input vec_t v);
    int          n;
    int          lat;
    int          n_en_a;
    int          n_en_b;
    int          n_valid;
    int          n_clear;
    logic [ADDR_W-1:0] ea;
    logic [ADDR_W-1:0] eb;
    logic [32:0] exp_e;
    logic [31:0] held;
    cmd_base_a = v.base_a;
    cmd_base_b = v.base_b;
    cmd_len    = v.len;
    cmd_valid  = 1'b1;
    res_ready  = v.early;
    n = 0;
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_accept", 32'(cmd_ready), 32'd1);
    sb_q.push_back({v.exp_ovf, v.exp_data});
    @(negedge clk);
    cmd_valid = 1'b0;
    lat = 0; n_en_a = 0; n_en_b = 0; n_valid = 0; n_clear = 0;
    while (!res_valid && lat < 300) begin
      if (mem_a_en) begin
        ea = v.base_a + ADDR_W'(n_en_a);
        chk("addr_a", 32'(mem_a_addr), 32'(ea));
        n_en_a++;
      end
      if (mem_b_en) begin
        eb = v.base_b + ADDR_W'(n_en_b);
        chk("addr_b", 32'(mem_b_addr), 32'(eb));
        n_en_b++;
      end
      if (mac_valid) n_valid++;
      if (mac_clear) n_clear++;
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, total_latency(CLR_WAIT, DRAIN_CYCLES, 32'(v.len)));
    chk("n_mem_a_en", n_en_a, 32'(v.len));
    chk("n_mem_b_en", n_en_b, 32'(v.len));
    chk("n_mac_valid", n_valid, 32'(v.len));
    chk("n_mac_clear", n_clear, 32'd1);
    exp_e = sb_q.pop_front();
    chk("res_data", res_data, exp_e[31:0]);
    chk("res_ovf", 32'(res_overflow), 32'(exp_e[32]));
    held = res_data;
    for (int h = 0; h < v.hold; h++) begin
      cmd_valid = 1'b1;
      @(negedge clk);
      chk("hold_valid", 32'(res_valid), 32'd1);
      chk("hold_data", res_data, held);
      chk("hold_ovf", 32'(res_overflow), 32'(exp_e[32]));
      chk("hold_cmd_blocked", 32'(cmd_ready), 32'd0);
    end
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk("res_valid_drop", 32'(res_valid), 32'd0);
    chk("cmd_ready_back", 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    int   n;
    int   n_en;
    logic seen_res;
    vec_t v_after_rst;

    for (int i = 0; i < 1024; i++) begin
      mem_a[i] = 32'h0;
      mem_b[i] = 32'h0;
    end
    mem_a[0] = 32'h3F800000; mem_a[1] = 32'h40000000;
    mem_a[2] = 32'h40400000; mem_a[3] = 32'h40800000;
    mem_a[10'h3FE] = 32'h40400000; mem_a[10'h3FF] = 32'h40800000;
    mem_a[10'h100] = 32'h7F7FFFFF; mem_a[10'h101] = 32'h7F7FFFFF;
    mem_a[10'h210] = 32'h3F800000;
    for (int i = 0; i < 4; i++) begin
      mem_b[16 + i]  = 32'h3F800000;
      mem_b[32 + i]  = 32'h40000000;
      mem_a[512 + i] = 32'h3F800000;
    end
    mem_b[10'h30] = 32'h40000000; mem_b[10'h31] = 32'h40000000;
    mem_b[10'h40] = 32'h40A00000;

    vecs[0] = '{10'h000, 10'h010, 11'd4, 32'h41200000, 1'b0, 20, 1'b0};
    vecs[1] = '{10'h3FE, 10'h020, 11'd4, 32'h41A00000, 1'b0, 0,  1'b0};
    vecs[2] = '{10'h000, 10'h020, 11'd3, 32'h41400000, 1'b0, 0,  1'b1};
    vecs[3] = '{10'h100, 10'h030, 11'd2, 32'h7F800000, 1'b1, 5,  1'b0};
    vecs[4] = '{10'h050, 10'h050, 11'd0, 32'h00000000, 1'b0, 0,  1'b0};

    rst = 1'b1; cmd_valid = 1'b0; cmd_base_a = '0; cmd_base_b = '0; cmd_len = '0;
    res_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_reset("reset");
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 5; i++) run_cmd(vecs[i]);

    // Abort a run with reset during its third issue cycle.
    cmd_base_a = 10'h200; cmd_base_b = 10'h010; cmd_len = 11'd4; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 0; n_en = 0;
    while (n < 50) begin
      if (mem_a_en) n_en++;
      if (n_en == 3) break;
      @(negedge clk);
      n++;
    end
    chk("abort_reach_issue3", n_en, 32'd3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset("abort");
    seen_res = 1'b0;
    repeat (15) begin
      @(negedge clk);
      seen_res = seen_res | res_valid | busy;
    end
    chk("abort_no_result", 32'(seen_res), 32'd0);

    v_after_rst = '{10'h210, 10'h040, 11'd1, 32'h40A00000, 1'b0, 0, 1'b0};
    run_cmd(v_after_rst);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
